button_strobe: RTL and testbench



---
 rtl/button_strobe_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/button_strobe.sv | 168 ++++++++++++++++
 tb/tb_button_strobe.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_strobe_pkg.sv
// Shared types and default timing constants for the push-button strobe front end.
package button_strobe_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } bs_state_t;

   localparam int BS_DB_CYCLES     = 500000;
   localparam int BS_REPEAT_DELAY  = 50000000;
   localparam int BS_REPEAT_PERIOD = 10000000;

   function automatic int bs_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_strobe.sv
// Debounces a raw button and turns each accepted press into a one-cycle FIFO write/read strobe.
// Optional auto-repeat while held is enabled by defining BUTTON_STROBE_AUTOREPEAT_EN.
module button_strobe
   import button_strobe_pkg::*;
#(
   parameter int DB_CYCLES     = BS_DB_CYCLES,
   parameter int REPEAT_DELAY  = BS_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = BS_REPEAT_PERIOD
) (
   input  logic clk100MHz,
   input  logic rst,
   input  logic button,
   input  logic wnr,
   input  logic en,
   input  logic full,
   input  logic empty,
   output logic wr_stb,
   output logic rd_stb,
   output logic blocked,
   output logic held
);

   // Sized one bit beyond the largest constant's log2 so the limit value itself is representable.
   localparam int CW = $clog2(bs_max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CW-1:0] DB_LIM = CW'(DB_CYCLES);

   logic            btn_s;
   bs_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            db_fire;
   logic            rep_fire;
   logic            fire;
   logic            wr_stb_q, wr_stb_d;
   logic            rd_stb_q, rd_stb_d;
   logic            blocked_q, blocked_d;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk (clk100MHz),
      .rst (rst),
      .d   (button),
      .q   (btn_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = CW'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LIM) begin
               state_d = HELD;
               cnt_d   = '0;
               db_fire = 1'b1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LIM) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk100MHz) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef BUTTON_STROBE_AUTOREPEAT_EN
   localparam logic [CW-1:0] REP_FIRST_LIM = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] REP_NEXT_LIM  = CW'(REPEAT_PERIOD - 1);

   logic [CW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_first_q, rep_first_d;

   // Timer only advances in HELD, so a release glitch pauses it rather than restarting it.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_fire    = 1'b0;
      if (state_q == IDLE) begin
         rep_cnt_d   = '0;
         rep_first_d = 1'b0;
      end else if (state_q == HELD) begin
         if (rep_cnt_q == (rep_first_q ? REP_NEXT_LIM : REP_FIRST_LIM)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
         end else begin
            rep_cnt_d   = rep_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk100MHz) begin
      if (rst) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign fire = db_fire | rep_fire;

   // Overflow/underflow protection: a fire the FIFO cannot take becomes a blocked pulse instead.
   always_comb begin
      wr_stb_d  = fire & en &  wnr & ~full;
      rd_stb_d  = fire & en & ~wnr & ~empty;
      blocked_d = fire & en & ((wnr & full) | (~wnr & empty));
   end

   always_ff @(posedge clk100MHz) begin
      if (rst) begin
         wr_stb_q  <= 1'b0;
         rd_stb_q  <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         wr_stb_q  <= wr_stb_d;
         rd_stb_q  <= rd_stb_d;
         blocked_q <= blocked_d;
      end
   end

   assign wr_stb  = wr_stb_q;
   assign rd_stb  = rd_stb_q;
   assign blocked = blocked_q;
   assign held    = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_button_strobe.sv
// Self-checking bench for button_strobe against a run-length debounce model.
// Honours BUTTON_STROBE_AUTOREPEAT_EN the same way the design does.
module tb_button_strobe;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic clk100MHz = 1'b0;
   logic rst       = 1'b1;
   logic button    = 1'b0;
   logic wnr       = 1'b1;
   logic en        = 1'b1;
   logic full      = 1'b0;
   logic empty     = 1'b0;
   logic wr_stb, rd_stb, blocked, held;

   int checks = 0;
   int fails  = 0;

   // Reference model: synchroniser delay line, debounced level, run of disagreeing samples.
   logic m_s1 = 1'b0, m_s2 = 1'b0, m_held = 1'b0;
   logic m_wr = 1'b0, m_rd = 1'b0, m_blk = 1'b0;
   logic m_rep_first = 1'b0;
   int   m_run = 0, m_rep = 0;

   button_strobe #(
      .DB_CYCLES     (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk100MHz (clk100MHz),
      .rst       (rst),
      .button    (button),
      .wnr       (wnr),
      .en        (en),
      .full      (full),
      .empty     (empty),
      .wr_stb    (wr_stb),
      .rd_stb    (rd_stb),
      .blocked   (blocked),
      .held      (held)
   );

   always #5 clk100MHz = ~clk100MHz;

   // A level change is accepted once the synchronised button disagrees with it for DB+1 edges.
   task automatic model_edge();
      logic bs, pre_held, in_held_state, fire;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_held = 0; m_run = 0; m_rep = 0; m_rep_first = 0;
         m_wr = 0; m_rd = 0; m_blk = 0;
         return;
      end
      bs            = m_s2;
      m_s2          = m_s1;
      m_s1          = button;
      pre_held      = m_held;
      in_held_state = m_held && (m_run == 0);
      fire          = 1'b0;
      if (bs != m_held) begin
         m_run++;
         if (m_run == DB + 1) begin
            m_held = bs;
            m_run  = 0;
            if (bs) fire = 1'b1;
         end
      end else begin
         m_run = 0;
      end
`ifdef BUTTON_STROBE_AUTOREPEAT_EN
      if (in_held_state) begin
         m_rep++;
         if (m_rep == (m_rep_first ? RP : RD)) begin
            fire        = 1'b1;
            m_rep       = 0;
            m_rep_first = 1'b1;
         end
      end else if (!pre_held) begin
         m_rep       = 0;
         m_rep_first = 1'b0;
      end
`else
      if (in_held_state && !pre_held) m_rep = 0;
`endif
      m_wr  = fire && en && wnr && !full;
      m_rd  = fire && en && !wnr && !empty;
      m_blk = fire && en && ((wnr && full) || (!wnr && empty));
   endtask

   task automatic tick();
      @(posedge clk100MHz);
      model_edge();
      #1;
   endtask

   task automatic settle();
      button = 1'b0;
      repeat (DB + 8) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({wr_stb, rd_stb, blocked, held} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %b expected 0000", {wr_stb, rd_stb, blocked, held});
      end
      rst = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_clean_press();
      int first_wr, n_wr, fall;
      first_wr = -1; n_wr = 0; fall = -1;
      wnr = 1; en = 1; full = 0; empty = 0;
      button = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL clean_press cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
         if (wr_stb) begin n_wr++; if (first_wr < 0) first_wr = i; end
      end
      checks++;
      if (first_wr !== DB + 2) begin
         fails++;
         $display("[TB] FAIL press_latency: got %0d expected %0d", first_wr, DB + 2);
      end
      checks++;
      if (n_wr !== 1 || held !== 1'b1) begin
         fails++;
         $display("[TB] FAIL press_single: strobes %0d held %b expected 1 and 1", n_wr, held);
      end
      button = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL release cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
         if (!held && fall < 0) fall = i;
      end
      checks++;
      if (fall !== DB + 2) begin
         fails++;
         $display("[TB] FAIL release_latency: got %0d expected %0d", fall, DB + 2);
      end
   endtask

   task automatic test_bounce();
      logic [3:0] pat;
      int n_bounce, first_wr;
      pat = 4'b0101;
      n_bounce = 0; first_wr = -1;
      wnr = 1; en = 1; full = 0;
      for (int i = 0; i < 4; i++) begin
         button = pat[i];
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL bounce cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
      end
      button = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL bounce_hold cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
         if (wr_stb && i < DB + 2) n_bounce++;
         if (wr_stb && first_wr < 0) first_wr = i;
      end
      checks++;
      if (n_bounce !== 0 || first_wr !== DB + 2) begin
         fails++;
         $display("[TB] FAIL bounce_latency: early %0d first %0d expected 0 and %0d",
                  n_bounce, first_wr, DB + 2);
      end
      settle();
   endtask

   task automatic test_gating();
      logic [3:0] cfg [4];
      int exp_wr [4];
      int exp_rd [4];
      int exp_bk [4];
      int n_wr, n_rd, n_bk;
      // {en, wnr, full, empty}
      cfg[0] = 4'b1001; exp_wr[0] = 0; exp_rd[0] = 0; exp_bk[0] = 1;
      cfg[1] = 4'b0001; exp_wr[1] = 0; exp_rd[1] = 0; exp_bk[1] = 0;
      cfg[2] = 4'b1110; exp_wr[2] = 0; exp_rd[2] = 0; exp_bk[2] = 1;
      cfg[3] = 4'b1000; exp_wr[3] = 0; exp_rd[3] = 1; exp_bk[3] = 0;
      for (int c = 0; c < 4; c++) begin
         {en, wnr, full, empty} = cfg[c];
         n_wr = 0; n_rd = 0; n_bk = 0;
         button = 1'b1;
         for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
               fails++;
               $display("[TB] FAIL gating%0d cyc %0d: got %b expected %b", c, i,
                        {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
            end
            n_wr += int'(wr_stb); n_rd += int'(rd_stb); n_bk += int'(blocked);
         end
         checks++;
         if (n_wr !== exp_wr[c] || n_rd !== exp_rd[c] || n_bk !== exp_bk[c]) begin
            fails++;
            $display("[TB] FAIL gating_counts%0d: wr/rd/blk %0d/%0d/%0d expected %0d/%0d/%0d",
                     c, n_wr, n_rd, n_bk, exp_wr[c], exp_rd[c], exp_bk[c]);
         end
         settle();
      end
      en = 1; wnr = 1; full = 0; empty = 0;
   endtask

   task automatic test_reset_mid_press();
      int first_wr;
      first_wr = -1;
      button = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({wr_stb, rd_stb, blocked, held} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_mid_press: got %b expected 0000", {wr_stb, rd_stb, blocked, held});
      end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL post_reset cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
         if (wr_stb && first_wr < 0) first_wr = i;
      end
      checks++;
      if (first_wr !== DB + 2) begin
         fails++;
         $display("[TB] FAIL post_reset_latency: got %0d expected %0d", first_wr, DB + 2);
      end
      settle();
   endtask

   task automatic test_release_glitch();
      int n_wr;
      logic held_min;
      n_wr = 0; held_min = 1'b1;
      button = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < 12; i++) begin
         button = (i == 0 || i == 1) ? 1'b0 : 1'b1;
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL glitch cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
         n_wr += int'(wr_stb);
         held_min &= held;
      end
      checks++;
      if (n_wr !== 0 || held_min !== 1'b1) begin
         fails++;
         $display("[TB] FAIL glitch_effect: strobes %0d held_min %b expected 0 and 1", n_wr, held_min);
      end
      settle();
   endtask

   task automatic test_autorepeat();
      int n_wr, exp_n;
`ifdef BUTTON_STROBE_AUTOREPEAT_EN
      exp_n = 6;
`else
      exp_n = 1;
`endif
      n_wr = 0;
      button = 1'b1;
      for (int i = 0; i < DB + 2 + 60; i++) begin
         tick();
         checks++;
         if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
            fails++;
            $display("[TB] FAIL autorepeat cyc %0d: got %b expected %b", i,
                     {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
         end
         n_wr += int'(wr_stb);
      end
      checks++;
      if (n_wr !== exp_n) begin
         fails++;
         $display("[TB] FAIL autorepeat_count: got %0d expected %0d", n_wr, exp_n);
      end
      settle();
   endtask

   task automatic test_random();
      int len;
      for (int s = 0; s < 40; s++) begin
         button = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
         for (int j = 0; j < len; j++) begin
            wnr   = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 3) != 0);
            full  = 1'($urandom_range(0, 1));
            empty = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({wr_stb, rd_stb, blocked, held} !== {m_wr, m_rd, m_blk, m_held}) begin
               fails++;
               $display("[TB] FAIL random seg %0d cyc %0d: got %b expected %b", s, j,
                        {wr_stb, rd_stb, blocked, held}, {m_wr, m_rd, m_blk, m_held});
            end
         end
      end
      settle();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_gating();
      test_reset_mid_press();
      test_release_glitch();
      test_autorepeat();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
